// File: rtl/aes_core_arbiter_if.sv
// rtl/aes_core_arbiter_if.sv - requester, response and core-side signals of the AES core arbiter
interface aes_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128,
  parameter int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*DATA_W-1:0] req_key;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      core_rstn;
  logic                      core_start;
  logic [DATA_W-1:0]         core_data;
  logic [DATA_W-1:0]         core_key;
  logic                      core_done;
  logic [DATA_W-1:0]         core_result;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;
  logic                      err;

  modport master (
    input  req_valid, req_data, req_key, rsp_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_data, core_rstn, core_start, core_data, core_key,
           grant_id, busy, err
  );

  modport slave (
    output req_valid, req_data, req_key, rsp_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_data, core_rstn, core_start, core_data, core_key,
           grant_id, busy, err
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin arbiter sharing one AES-128 core among NUM_REQ requesters
// Optional RUN watchdog enabled by defining AES_ARB_WDOG_EN.
module aes_core_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 128,
  parameter int WDOG_CYC = 15,
  parameter int GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                clk,
  input logic                rst,
  aes_core_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  state_e              state_q;
  logic [GID_W-1:0]    ptr_q, grant_q;
  logic [NUM_REQ-1:0]  req_ready_q, rsp_valid_q;
  logic                core_rstn_q, core_start_q;
  logic [DATA_W-1:0]   core_data_q, core_key_q, rsp_data_q;
  logic [GID_W-1:0]    cand_d, win_idx_d;
  logic                win_found_d;
  logic [DATA_W-1:0]   win_data_d, win_key_d;

  // Search upward from the requester after the last winner, wrapping at NUM_REQ.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand_d      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_d = GID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found_d && bus.req_valid[cand_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d;
      end
    end
    win_data_d = bus.req_data[int'(win_idx_d)*DATA_W +: DATA_W];
    win_key_d  = bus.req_key[int'(win_idx_d)*DATA_W +: DATA_W];
  end

`ifdef AES_ARB_WDOG_EN
  localparam int WC_W = $clog2(WDOG_CYC + 1);
  logic [WC_W-1:0] wcnt_q;
  logic            err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= GID_W'(NUM_REQ - 1);
      grant_q      <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      core_rstn_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_data_q  <= '0;
      core_key_q   <= '0;
      rsp_data_q   <= '0;
`ifdef AES_ARB_WDOG_EN
      wcnt_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            core_data_q <= win_data_d;
            core_key_q  <= win_key_d;
            grant_q     <= win_idx_d;
            req_ready_q <= NUM_REQ'(1) << win_idx_d;
            state_q     <= LOAD;
`ifdef AES_ARB_WDOG_EN
            wcnt_q      <= '0;
`endif
          end
        end
        LOAD: begin
          core_rstn_q  <= 1'b1;
          core_start_q <= 1'b1;
          state_q      <= RUN;
        end
        RUN: begin
          // Dropping core_rstn with start lets RESP discard the core's own restart.
          if (bus.core_done) begin
            rsp_data_q   <= bus.core_result;
            rsp_valid_q  <= NUM_REQ'(1) << grant_q;
            core_start_q <= 1'b0;
            core_rstn_q  <= 1'b0;
            state_q      <= RESP;
          end
`ifdef AES_ARB_WDOG_EN
          else if (wcnt_q == WC_W'(WDOG_CYC - 1)) begin
            err_q        <= 1'b1;
            rsp_data_q   <= '0;
            rsp_valid_q  <= NUM_REQ'(1) << grant_q;
            core_start_q <= 1'b0;
            core_rstn_q  <= 1'b0;
            state_q      <= RESP;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= grant_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.core_rstn  = core_rstn_q;
  assign bus.core_start = core_start_q;
  assign bus.core_data  = core_data_q;
  assign bus.core_key   = core_key_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef AES_ARB_WDOG_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif
endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Round-robin arbiter that shares one AES-128 core (round controller plus datapath) among NUM_REQ requesters.
- Each requester hands over a plaintext/key pair with a valid/ready handshake and later receives the ciphertext on a per-requester response handshake.
- Sequences the core: holds it cleared while idle, drives its start level for one full encryption, captures the result on the core's done pulse.
- Sits between the system-side clients and the core's start/rstn/done interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 128, plaintext/key/ciphertext width.
- WDOG_CYC, 15, watchdog limit in RUN cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_data  in  NUM_REQ*DATA_W  plaintexts; requester i occupies bits [i*DATA_W +: DATA_W].
- req_key  in  NUM_REQ*DATA_W  keys, same packing as req_data.
- rsp_valid  out  NUM_REQ  one-hot result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  DATA_W  shared ciphertext bus, meaningful while any rsp_valid is high.
- core_rstn  out  1  active-low clear to core controller.
- core_start  out  1  start level to core controller.
- core_data  out  DATA_W  registered plaintext to core.
- core_key  out  DATA_W  registered key to core.
- core_done  in  1  core completion pulse (one cycle).
- core_result  in  DATA_W  core ciphertext, valid when core_done=1.
- grant_id  out  clog2(NUM_REQ)  index of current owner.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - state=IDLE; all of req_ready, rsp_valid, core_start, busy, err = 0; core_rstn=0.
  - core_data, core_key, rsp_data = 0; grant_id=0.
  - Last-winner pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-job aborts immediately: no response is issued and the job is lost.
- States: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - Any req_valid high: winner = first set bit searching upward from pointer+1, modulo NUM_REQ.
  - Register the winner's data/key into core_data/core_key, set grant_id, pulse req_ready[winner] for exactly one cycle (registered, so it is high in the first LOAD cycle). Next state LOAD.
  - Requester i must hold req_valid and its data until it sees req_ready[i]=1.
  - req_valid dropping before grant is legal; no request is latched.
- LOAD: one cycle. core_rstn goes to 1 with core_start=1, so the core sees round 0 with start high on the next edge. Next state RUN.
- RUN:
  - core_rstn=1 and core_start=1 held until core_done=1 is sampled.
  - Then register rsp_data<=core_result, set rsp_valid[grant_id]=1, core_start<=0, core_rstn<=0. Next state RESP.
  - The core's controller clears in RESP, so its restart on that same edge is discarded.
  - Nominal RUN length is 11 cycles; the arbiter must not depend on the count.
- RESP:
  - rsp_valid[grant_id] and rsp_data held stable until rsp_ready[grant_id]=1.
  - Then rsp_valid=0, pointer<=grant_id, next state IDLE.
  - rsp_ready on other bits is ignored.
- New requests arriving during LOAD/RUN/RESP wait; arbitration happens only in IDLE.
- Minimum back-to-back spacing: 1 IDLE cycle between jobs.
- Fairness: a requester with valid held high is granted within NUM_REQ jobs.
- req_ready and rsp_valid are one-hot or zero at all times.

Optional Feature:
- Macro AES_ARB_WDOG_EN.
- Defined:
  - A RUN-cycle counter (width clog2(WDOG_CYC+1)) clears on LOAD entry.
  - If it reaches WDOG_CYC without core_done, then: err<=1 (sticky until rst), core_start<=0, core_rstn<=0, rsp_data<=0, and rsp_valid[grant_id] is raised so the owner is released.
  - RESP then proceeds normally.
  - core_done and timeout in the same cycle: core_done wins, err stays 0.
- Not defined: no counter, err tied 0, RUN waits indefinitely.

Test Plan:
- Single request: req_valid=0001, data=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, rsp_ready=1 -> req_ready[0] pulses once; rsp_valid[0] with rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a; core_start high 11 cycles.
- Contention: req_valid=1111 held, rsp_ready=1111 -> grant order 0,1,2,3,0; each pair of grants separated by one full job.
- Backpressure: rsp_ready[2]=0 for 20 cycles after rsp_valid[2] -> rsp_valid/rsp_data stable, busy=1, no new req_ready; release -> IDLE next cycle.
- Withdrawn request: req_valid[1] high 1 cycle while busy, then low -> never granted; pointer unchanged.
- Reset mid-RUN: rst high 1 cycle at RUN cycle 5 -> all outputs at reset values next cycle; next grant goes to requester 0.
- AES_ARB_WDOG_EN with core_done stuck 0 -> after 15 RUN cycles err=1, rsp_valid[owner]=1, rsp_data=0; err stays 1 across later good jobs until rst.
